// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencing controller: FSM states,
// control-byte field positions and the reload value used at reset.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        LD_WE,
        RD_H0,
        RD_L,
        RD_H1
    } timer_ctrl_state_t;

    localparam int CTL_SEG     = 0;
    localparam int CTL_WE      = 1;
    localparam int CTL_INTEN   = 2;
    localparam int CTL_PER_LSB = 3;
    localparam int CTL_PER_MSB = 7;

    localparam logic [15:0] TMR_RELOAD_RST = 16'hFFFF;

endpackage

// File: rtl/timer_irq_latch.sv
// Sticky interrupt pending/overrun flags; a new interrupt arriving in the
// same cycle as an acknowledge is kept pending rather than lost.
module timer_irq_latch
    import timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic irq_ack,
    output logic irq_pending,
    output logic irq_overrun
);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pending <= 1'b0;
            irq_overrun <= 1'b0;
        end else if (irq_in) begin
            irq_pending <= 1'b1;
            if (irq_ack)
                irq_overrun <= 1'b0;
            else if (irq_pending)
                irq_overrun <= 1'b1;
        end else if (irq_ack) begin
            irq_pending <= 1'b0;
            irq_overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Sequences byte-serial reloads into the 8-bit-port timer, performs
// tear-free 16-bit readback of its count and latches its interrupt.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cfg_period,
    input  logic        cfg_int_en,
    input  logic        load_req,
    input  logic [15:0] load_val,
    output logic        load_ack,
    input  logic        rd_req,
    output logic [15:0] rd_val,
    output logic        rd_valid,
    output logic        busy,
    input  logic        irq_in,
    input  logic        irq_ack,
    output logic        irq_pending,
    output logic        irq_overrun,
    output logic [7:0]  tmr_control,
    output logic [7:0]  tmr_set,
    input  logic [7:0]  tmr_read
);

    timer_ctrl_state_t state, next_state;

    logic [15:0] shadow;
    logic [4:0]  cfg_per;
    logic        cfg_int_en_q;
    logic [7:0]  h0;
    logic [7:0]  lo;
    logic [2:0]  retry;
    logic        seg;
    logic        we;
    logic        retry_left;

    assign retry_left = (retry < 3'(MAX_RETRY));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Timer-facing strobes depend only on registered state so the timer never
    // sees a glitch caused by a bus-side input.
    always_comb begin
        next_state = state;
        seg        = 1'b0;
        we         = 1'b0;
        tmr_set    = shadow[7:0];
        case (state)
            IDLE: begin
                if (load_req)
                    next_state = LD_LO;
                else if (rd_req)
                    next_state = RD_H0;
            end
            LD_LO: next_state = LD_HI;
            LD_HI: begin
                seg        = 1'b1;
                tmr_set    = shadow[15:8];
                next_state = LD_WE;
            end
            LD_WE: begin
                seg        = 1'b1;
                we         = 1'b1;
                tmr_set    = shadow[15:8];
                next_state = IDLE;
            end
            RD_H0: begin
                seg        = 1'b1;
                next_state = RD_L;
            end
            RD_L: next_state = RD_H1;
            RD_H1: begin
                seg = 1'b1;
                if (tmr_read != h0 && retry_left)
                    next_state = RD_L;
                else
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tmr_control                          = '0;
        tmr_control[CTL_PER_MSB:CTL_PER_LSB] = cfg_per;
        tmr_control[CTL_INTEN]               = cfg_int_en_q;
        tmr_control[CTL_WE]                  = we;
        tmr_control[CTL_SEG]                 = seg;
    end

    // A high byte that changed between the two samples means the low byte may
    // belong to either value, so the low byte is re-read against the newer high.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow       <= TMR_RELOAD_RST;
            cfg_per      <= '0;
            cfg_int_en_q <= 1'b0;
            h0           <= '0;
            lo           <= '0;
            retry        <= '0;
            rd_val       <= '0;
            load_ack     <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            cfg_per      <= cfg_period;
            cfg_int_en_q <= cfg_int_en;
            load_ack     <= 1'b0;
            rd_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req)
                        shadow <= load_val;
                    else if (rd_req)
                        retry <= '0;
                end
                LD_WE: load_ack <= 1'b1;
                RD_H0: h0 <= tmr_read;
                RD_L:  lo <= tmr_read;
                RD_H1: begin
                    if (tmr_read == h0) begin
                        rd_val   <= {h0, lo};
                        rd_valid <= 1'b1;
                    end else if (retry_left) begin
                        h0    <= tmr_read;
                        retry <= retry + 3'd1;
                    end else begin
                        rd_val   <= {tmr_read, lo};
                        rd_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    timer_irq_latch u_irq_latch (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending),
        .irq_overrun (irq_overrun)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a transaction-level model predicts every output each
// cycle, and directed scenarios add hand-computed latencies and values.
module tb_timer_ctrl;

    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cfg_period;
    logic        cfg_int_en;
    logic        load_req;
    logic [15:0] load_val;
    logic        load_ack;
    logic        rd_req;
    logic [15:0] rd_val;
    logic        rd_valid;
    logic        busy;
    logic        irq_in;
    logic        irq_ack;
    logic        irq_pending;
    logic        irq_overrun;
    logic [7:0]  tmr_control;
    logic [7:0]  tmr_set;
    logic [7:0]  tmr_read;

    int compared   = 0;
    int mismatched = 0;

    timer_ctrl #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_period  (cfg_period),
        .cfg_int_en  (cfg_int_en),
        .load_req    (load_req),
        .load_val    (load_val),
        .load_ack    (load_ack),
        .rd_req      (rd_req),
        .rd_val      (rd_val),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .irq_in      (irq_in),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending),
        .irq_overrun (irq_overrun),
        .tmr_control (tmr_control),
        .tmr_set     (tmr_set),
        .tmr_read    (tmr_read)
    );

    always #5 clk = ~clk;

    // Stand-in timer: reports timerVal by segment and commits a reload on we.
    logic [15:0] timerVal;
    logic [7:0]  stagedLo;
    logic [15:0] tbReload;

    assign tmr_read = tmr_control[0] ? timerVal[15:8] : timerVal[7:0];

    always @(negedge clk) begin
        if (tmr_control[1])
            tbReload <= {tmr_set, stagedLo};
        if (!tmr_control[0])
            stagedLo <= tmr_set;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: expected outputs for the cycle that begins at each edge.
    logic        modelStarted = 1'b0;
    logic        eBusy, eSeg, eWe, eLoadAck, eRdValid, ePend, eOvr, eIntEn;
    logic [7:0]  eSet, capByte, loByte, hiByte;
    logic [15:0] eShadow, eRdVal;
    logic [4:0]  ePer;
    int          loadLeft, retries;
    logic        reading, wantHigh, haveHigh;

    initial begin
        forever begin
            @(posedge clk);
            modelStarted = 1'b1;
            if (reset) begin
                eShadow = 16'hFFFF; ePer = '0; eIntEn = 1'b0; eRdVal = '0;
                eLoadAck = 1'b0; eRdValid = 1'b0; ePend = 1'b0; eOvr = 1'b0;
                loadLeft = 0; reading = 1'b0; wantHigh = 1'b0; haveHigh = 1'b0;
                retries = 0; loByte = '0; hiByte = '0;
            end else begin
                if (irq_in) begin
                    if (irq_ack) eOvr = 1'b0;
                    else if (ePend) eOvr = 1'b1;
                    ePend = 1'b1;
                end else if (irq_ack) begin
                    ePend = 1'b0;
                    eOvr  = 1'b0;
                end
                ePer = cfg_period;
                eIntEn = cfg_int_en;
                eLoadAck = 1'b0;
                eRdValid = 1'b0;
                if (loadLeft > 0) begin
                    loadLeft--;
                    if (loadLeft == 0) eLoadAck = 1'b1;
                end else if (reading) begin
                    capByte = wantHigh ? timerVal[15:8] : timerVal[7:0];
                    if (!wantHigh) begin
                        loByte = capByte;
                        wantHigh = 1'b1;
                    end else if (!haveHigh) begin
                        hiByte = capByte;
                        haveHigh = 1'b1;
                        wantHigh = 1'b0;
                    end else if (capByte == hiByte || retries == MAX_RETRY) begin
                        eRdVal = {capByte, loByte};
                        eRdValid = 1'b1;
                        reading = 1'b0;
                    end else begin
                        hiByte = capByte;
                        retries++;
                        wantHigh = 1'b0;
                    end
                end else if (load_req) begin
                    eShadow = load_val;
                    loadLeft = 3;
                end else if (rd_req) begin
                    reading = 1'b1; haveHigh = 1'b0; wantHigh = 1'b1; retries = 0;
                end
            end
            eBusy = (loadLeft > 0) || reading;
            eSeg  = reading ? wantHigh : (loadLeft == 2 || loadLeft == 1);
            eWe   = (loadLeft == 1);
            eSet  = (loadLeft == 2 || loadLeft == 1) ? eShadow[15:8] : eShadow[7:0];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (modelStarted) begin
                checkOutput("busy", 16'(busy), 16'(eBusy));
                checkOutput("load_ack", 16'(load_ack), 16'(eLoadAck));
                checkOutput("rd_valid", 16'(rd_valid), 16'(eRdValid));
                checkOutput("rd_val", rd_val, eRdVal);
                checkOutput("irq_pending", 16'(irq_pending), 16'(ePend));
                checkOutput("irq_overrun", 16'(irq_overrun), 16'(eOvr));
                checkOutput("tmr_control", 16'(tmr_control), 16'({ePer, eIntEn, eWe, eSeg}));
                if (!reading)
                    checkOutput("tmr_set", 16'(tmr_set), 16'(eSet));
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    // Counts edges until the selected pulse (0 = load_ack, 1 = rd_valid) shows.
    task automatic waitFlag(input int which, output int n);
        n = -1;
        for (int i = 0; i < 30; i++) begin
            waitCycle();
            if ((which == 0) ? load_ack : rd_valid) begin
                n = i + 1;
                return;
            end
        end
    endtask

    task automatic applyStimulus();
        int n;
        reset = 1'b1; cfg_period = '0; cfg_int_en = 1'b0;
        load_req = 1'b0; load_val = '0; rd_req = 1'b0;
        irq_in = 1'b0; irq_ack = 1'b0; timerVal = '0;
        repeat (2) waitCycle();
        checkOutput("rst_control", 16'(tmr_control), 16'h0000);
        checkOutput("rst_set", 16'(tmr_set), 16'h00FF);
        checkOutput("rst_rd_val", rd_val, 16'h0000);
        reset = 1'b0;
        cfg_period = 5'h15; cfg_int_en = 1'b1;
        repeat (2) waitCycle();

        // Reload 0x1234: low byte, high byte, then write-enable.
        load_val = 16'h1234; load_req = 1'b1;
        waitCycle();
        checkOutput("ld1_wseg", 16'(tmr_control[1:0]), 16'h0000);
        checkOutput("ld1_set", 16'(tmr_set), 16'h0034);
        waitCycle();
        checkOutput("ld2_wseg", 16'(tmr_control[1:0]), 16'h0001);
        checkOutput("ld2_set", 16'(tmr_set), 16'h0012);
        waitCycle();
        checkOutput("ld3_wseg", 16'(tmr_control[1:0]), 16'h0003);
        checkOutput("ld3_set", 16'(tmr_set), 16'h0012);
        checkOutput("ld3_noack", 16'(load_ack), 16'h0000);
        waitCycle();
        checkOutput("ld_ack_cycle4", 16'(load_ack), 16'h0001);
        load_req = 1'b0;
        waitCycle();
        checkOutput("ld_reload", tbReload, 16'h1234);

        // Steady count: no retry.
        timerVal = 16'hA55A; rd_req = 1'b1;
        waitFlag(1, n);
        checkOutput("rd_latency", 16'(n), 16'd4);
        checkOutput("rd_value", rd_val, 16'hA55A);
        rd_req = 1'b0;
        waitCycle();

        // Torn read: high byte rolls from 01 to 00 after the low byte is sampled.
        timerVal = 16'h0100; rd_req = 1'b1;
        repeat (3) waitCycle();
        timerVal = 16'h00FF;
        waitFlag(1, n);
        checkOutput("torn_latency", 16'(n + 3), 16'd6);
        checkOutput("torn_value", rd_val, 16'h00FF);
        rd_req = 1'b0;
        waitCycle();

        // Simultaneous requests: load wins, held read follows the ack.
        load_val = 16'hBEEF; timerVal = 16'h1357;
        load_req = 1'b1; rd_req = 1'b1;
        waitFlag(0, n);
        checkOutput("prio_ld_latency", 16'(n), 16'd4);
        checkOutput("prio_no_rd", 16'(rd_valid), 16'h0000);
        load_req = 1'b0;
        waitFlag(1, n);
        checkOutput("prio_rd_latency", 16'(n), 16'd4);
        checkOutput("prio_rd_value", rd_val, 16'h1357);
        checkOutput("prio_reload", tbReload, 16'hBEEF);
        rd_req = 1'b0;
        waitCycle();

        // Interrupt latch.
        irq_in = 1'b1; waitCycle(); irq_in = 1'b0;
        checkOutput("irq_pend1", 16'({irq_pending, irq_overrun}), 16'h0002);
        irq_in = 1'b1; waitCycle(); irq_in = 1'b0;
        checkOutput("irq_ovr", 16'({irq_pending, irq_overrun}), 16'h0003);
        irq_in = 1'b1; irq_ack = 1'b1; waitCycle(); irq_in = 1'b0;
        checkOutput("irq_in_ack", 16'({irq_pending, irq_overrun}), 16'h0002);
        waitCycle(); irq_ack = 1'b0;
        checkOutput("irq_ack", 16'({irq_pending, irq_overrun}), 16'h0000);

        // Reset while in LD_HI aborts the load without an ack.
        load_val = 16'h5678; load_req = 1'b1;
        repeat (2) waitCycle();
        checkOutput("mid_in_ldhi", 16'(tmr_control[1:0]), 16'h0001);
        reset = 1'b1; load_req = 1'b0;
        waitCycle();
        reset = 1'b0;
        checkOutput("mid_busy", 16'(busy), 16'h0000);
        checkOutput("mid_control", 16'(tmr_control), 16'h0000);
        checkOutput("mid_set", 16'(tmr_set), 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("mid_no_ack", 16'(load_ack), 16'h0000);
            waitCycle();
        end
    endtask

    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
